// File: rtl/bus_remap_pkg.sv
// Shared types and constants for the bus bit-remap stage and its skid buffer.
package bus_remap_pkg;

    // Source-index width for a bus of the given width (width >= 2).
    function automatic int sel_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam logic [1:0] SKID_EMPTY = 2'd0;
    localparam logic [1:0] SKID_ONE   = 2'd1;
    localparam logic [1:0] SKID_TWO   = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = SKID_EMPTY,
        ST_ONE   = SKID_ONE,
        ST_TWO   = SKID_TWO
    } skid_state_e;

    // A table entry out of reset is disabled and points at its own index.
    localparam logic DEFAULT_EN = 1'b0;

endpackage

// File: rtl/bus_skid_buffer.sv
// Generic two-entry valid/ready buffer: a main output register plus one skid register.
module bus_skid_buffer
    import bus_remap_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_payload_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [PW-1:0] out_payload_o
);

    skid_state_e   state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_xfer;
    logic          out_xfer;

    // Ready and valid decode straight from the state register, so both are glitch-free registered signals.
    assign in_ready_o    = (state_q != ST_TWO);
    assign out_valid_o   = (state_q != ST_EMPTY);
    assign out_payload_o = main_q;

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_payload_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_payload_i;
                end else if (in_xfer) begin
                    skid_d  = in_payload_i;
                    state_d = ST_TWO;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // No input can arrive here; the older beat in main leaves first.
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/bus_bit_remap_stage.sv
// Registered, handshaked bit-remap stage: each sink bit copies a programmable source bit or is forced to 0.
module bus_bit_remap_stage
    import bus_remap_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SEL_W = sel_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_dst,
    input  logic [SEL_W-1:0] cfg_src,
    input  logic             cfg_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_mask,
    output logic [15:0]      beat_cnt
);

    logic [WIDTH-1:0] en_q, en_d;
    logic [SEL_W-1:0] src_q [WIDTH];
    logic [SEL_W-1:0] src_d [WIDTH];
    logic             cfg_wr_ok;
    logic [WIDTH-1:0] remap_data;
    logic [WIDTH-1:0] remap_mask;
    logic [15:0]      beat_cnt_q, beat_cnt_d;

    // Out-of-range indices only exist for non-power-of-2 widths; such writes are dropped.
    assign cfg_wr_ok = cfg_we
                     && ({1'b0, cfg_dst} < (SEL_W+1)'(WIDTH))
                     && ({1'b0, cfg_src} < (SEL_W+1)'(WIDTH));

    always_comb begin
        en_d  = en_q;
        src_d = src_q;
        if (cfg_wr_ok) begin
            en_d[cfg_dst]  = cfg_en;
            src_d[cfg_dst] = cfg_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                en_q[i]  <= DEFAULT_EN;
                src_q[i] <= SEL_W'(i);
            end
        end else begin
            en_q  <= en_d;
            src_q <= src_d;
        end
    end

    // Uses the table as it stands before this edge, so a beat accepted alongside a write sees the old map.
    always_comb begin
        remap_data = '0;
        remap_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            remap_mask[i] = en_q[i];
            if (en_q[i]) begin
                remap_data[i] = in_data[src_q[i]];
            end
        end
    end

    bus_skid_buffer #(
        .PW (2 * WIDTH)
    ) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_payload_i  ({remap_mask, remap_data}),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_payload_o ({out_mask, out_data})
    );

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_valid && out_ready) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;

endmodule

// File: doc/bus_bit_remap_stage.md
Name: bus_bit_remap_stage

Overview:
- Registered, handshaked bit-remap stage placed directly upstream of a sink bus.
- Each destination bit either copies a run-time-selected source bit or is left unmapped and driven to 0.
- The remap table is programmed through a small config port.
- It produces the sparse, non-contiguous bit assignments that downstream sink stages consume, with valid/ready flow control and full throughput.

Parameters:
- WIDTH, 4, width of the source and sink buses (must be at least 2).
- SEL_W, $clog2(WIDTH), width of a source-bit index.

Ports:
- clk  input  1  single clock; all state is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_we  input  1  write strobe for one remap entry.
- cfg_dst  input  SEL_W  destination bit index being written.
- cfg_src  input  SEL_W  source bit index for that destination.
- cfg_en  input  1  1 = destination bit is mapped, 0 = destination bit is unmapped (drives 0).
- in_valid  input  1  source beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  WIDTH  source bus.
- out_valid  output  1  remapped beat valid.
- out_ready  input  1  sink accepts the beat.
- out_data  output  WIDTH  remapped sink bus.
- out_mask  output  WIDTH  the remap-table enables that were used for this beat.
- beat_cnt  output  16  count of beats delivered (out_valid & out_ready), wrapping.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_mask=0, beat_cnt=0, in_ready=1.
  - Every table entry: en=0, src=own index.
  - Skid buffer empty.
- Remap function: dst[i] = en[i] ? in_data[src[i]] : 0; mask[i] = en[i]. The function is combinational on the input side and registered at capture.
- Config writes:
  - cfg_we takes effect at the clock edge.
  - A beat accepted on the same edge as a write uses the old table. Beats accepted on later edges use the new one.
  - cfg_dst or cfg_src >= WIDTH (possible only when WIDTH is not a power of 2): the write is ignored.
- Several destinations may select the same source bit; that is legal (fan-out).
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - out_valid/out_data/out_mask must hold steady while out_valid=1 & out_ready=0.
  - in_ready is a registered signal: in_ready = !skid_full.
- Datapath: 2-entry buffer made of the main output register plus one skid register.
  - Latency is 1 cycle: a beat accepted at edge N is presented at out_* after edge N.
  - Throughput is 1 beat/cycle while out_ready=1.
- Skid buffer states: EMPTY, ONE (main register full), TWO (main and skid full).
  - EMPTY + in xfer -> ONE.
  - ONE + in xfer + out xfer -> ONE.
  - ONE + in xfer, no out xfer -> TWO (in_ready drops the next cycle).
  - ONE + out xfer only -> EMPTY.
  - TWO + out xfer -> ONE, with the skid entry moved into the main register. No input is accepted in TWO because in_ready=0.
- Ordering: beats are strictly FIFO. There is no drop and no duplication.
- beat_cnt increments on each output transfer and wraps from 0xFFFF to 0.
- Reset asserted mid-transfer: buffered beats are discarded, and the table returns to all-disabled.

Decomposition:
- Shared package bus_remap_pkg holds:
  - the SEL_W computation function;
  - localparams for the skid states (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the default table entry constants.
- One natural sub-module: bus_skid_buffer.
  - It is a generic 2-entry valid/ready buffer with a payload of WIDTH*2 bits (data plus mask).
  - The remap table and remap function stay in the top module.

Test Plan:
- Reset, then in_data=4'b1111 with no config writes -> out_data=4'b0000, out_mask=4'b0000 one cycle later, beat_cnt=1.
- Write dst3<-src3 and dst2<-src1 (en=1), then in_data=4'b1010 -> out_data=4'b1100, out_mask=4'b1100. With in_data=4'b0101 -> out_data=4'b0000.
- Streaming 8 beats with out_ready=1 -> 8 beats delivered in 8 consecutive cycles, in order, beat_cnt=8.
- Hold out_ready=0 for 3 cycles while in_valid=1 -> 2 beats buffered, in_ready=0 after the second, out_* stable. Release out_ready -> both beats delivered in order, with no loss.
- cfg write dst0<-src2 on the same edge as a beat is accepted -> that beat uses the old map (bit0=0); the next beat gets bit0=in_data[2].
- Assert rst_n low while in state TWO -> out_valid=0 and in_ready=1 immediately (asynchronous), table cleared, and the post-reset beat remaps to 0.
